// File: rtl/expr_arb_pkg.sv
// Shared definitions for the expression round-robin arbiter: operand layout,
// slot state encoding and the boolean evaluator Y = ~A&B | C&~D | A&~B&D.
// Optional feature macro used by the top level: EXPR_ARB_GRANT_CNT_EN.
package expr_arb_pkg;

   localparam int OPND_W = 4;

   // Bit positions of the operand fields inside an {A,B,C,D} nibble
   localparam int A_BIT = 3;
   localparam int B_BIT = 2;
   localparam int C_BIT = 1;
   localparam int D_BIT = 0;

   typedef enum logic [0:0] {
      SLOT_EMPTY = 1'b0,
      SLOT_FULL  = 1'b1
   } slot_state_t;

   // The shared evaluator; every requester's operand goes through this one function
   function automatic logic expr_f(input logic [OPND_W-1:0] abcd);
      return (~abcd[A_BIT] &  abcd[B_BIT])
           | ( abcd[C_BIT] & ~abcd[D_BIT])
           | ( abcd[A_BIT] & ~abcd[B_BIT] & abcd[D_BIT]);
   endfunction

endpackage

// File: rtl/expr_rr_arbiter_pick.sv
// Combinational round-robin picker. Searches the request vector starting one
// position after the last grant and wrapping, returning a one-hot grant, its
// binary index and whether anything was found. Holds no state, so any arbiter
// can reuse it with its own pointer register.
module rr_pick #(
   parameter  int N  = 4,
   localparam int IW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]  req_i,
   input  logic [IW-1:0] lastGnt_i,
   output logic [N-1:0]  gnt_o,
   output logic [IW-1:0] gntIdx_o,
   output logic          gntAny_o
);

   // Walk the candidates from farthest to nearest so the nearest requester wins
   always_comb begin
      int            cand;
      logic [IW-1:0] candIdx;
      gnt_o    = '0;
      gntIdx_o = '0;
      gntAny_o = 1'b0;
      cand     = 0;
      candIdx  = '0;
      for (int k = N; k >= 1; k--) begin
         cand    = (int'(lastGnt_i) + k) % N;
         candIdx = IW'(cand);
         if (req_i[candIdx]) begin
            gnt_o          = '0;
            gnt_o[candIdx] = 1'b1;
            gntIdx_o       = candIdx;
            gntAny_o       = 1'b1;
         end
      end
   end

endmodule

// File: rtl/expr_rr_arbiter.sv
// Round-robin arbiter sharing one {A,B,C,D} boolean evaluator among NUM_REQ
// requesters. Results land in a single registered response slot tagged with
// the requester index; the slot can be drained and refilled in the same cycle.
// Optional feature macro: EXPR_ARB_GRANT_CNT_EN adds a saturating 16-bit
// count of accepted requester handshakes on port grant_cnt.
module expr_rr_arbiter
   import expr_arb_pkg::*;
#(
   parameter  int NUM_REQ = 4,
   localparam int ID_W    = $clog2(NUM_REQ)
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [NUM_REQ-1:0]        req_valid,
   output logic [NUM_REQ-1:0]        req_ready,
   input  logic [OPND_W*NUM_REQ-1:0] req_abcd,
   output logic                      rsp_valid,
   input  logic                      rsp_ready,
   output logic [ID_W-1:0]           rsp_id,
   output logic                      rsp_y,
   output logic [OPND_W-1:0]         rsp_abcd,
   output logic                      busy
`ifdef EXPR_ARB_GRANT_CNT_EN
   ,
   output logic [15:0]               grant_cnt
`endif
);

   slot_state_t         slotState_q;
   logic [ID_W-1:0]     rspId_q;
   logic                rspY_q;
   logic [OPND_W-1:0]   rspAbcd_q;
   logic [ID_W-1:0]     lastGnt_q;

   logic [NUM_REQ-1:0]  pickGnt;
   logic [ID_W-1:0]     pickIdx;
   logic                pickAny;
   logic                canAccept;
   logic                handshake;
   logic [OPND_W-1:0]   selAbcd_d;
   logic                selY_d;

   rr_pick #(
      .N (NUM_REQ)
   ) u_pick (
      .req_i     (req_valid),
      .lastGnt_i (lastGnt_q),
      .gnt_o     (pickGnt),
      .gntIdx_o  (pickIdx),
      .gntAny_o  (pickAny)
   );

   // The slot can take a new result when empty or when it is being drained this cycle
   always_comb begin
      canAccept = (slotState_q == SLOT_EMPTY) | rsp_ready;
      req_ready = '0;
      if (!rst && canAccept && pickAny) begin
         req_ready = pickGnt;
      end
      handshake = |(req_valid & req_ready);
      selAbcd_d = req_abcd[pickIdx*OPND_W +: OPND_W];
      selY_d    = expr_f(selAbcd_d);
   end

   // Slot state machine: load on any handshake, empty only on a drain without refill
   always_ff @(posedge clk) begin
      if (rst) begin
         slotState_q <= SLOT_EMPTY;
         rspId_q     <= '0;
         rspY_q      <= 1'b0;
         rspAbcd_q   <= '0;
         lastGnt_q   <= ID_W'(NUM_REQ - 1);
      end else begin
         case (slotState_q)
            SLOT_EMPTY: begin
               if (handshake) begin
                  slotState_q <= SLOT_FULL;
                  rspId_q     <= pickIdx;
                  rspY_q      <= selY_d;
                  rspAbcd_q   <= selAbcd_d;
                  lastGnt_q   <= pickIdx;
               end
            end
            SLOT_FULL: begin
               if (handshake) begin
                  slotState_q <= SLOT_FULL;
                  rspId_q     <= pickIdx;
                  rspY_q      <= selY_d;
                  rspAbcd_q   <= selAbcd_d;
                  lastGnt_q   <= pickIdx;
               end else if (rsp_ready) begin
                  slotState_q <= SLOT_EMPTY;
               end
            end
            default: begin
               slotState_q <= SLOT_EMPTY;
            end
         endcase
      end
   end

`ifdef EXPR_ARB_GRANT_CNT_EN
   logic [15:0] grantCnt_q;

   // Count slot loads, sticking at all-ones instead of wrapping
   always_ff @(posedge clk) begin
      if (rst) begin
         grantCnt_q <= '0;
      end else if (handshake && (grantCnt_q != 16'hFFFF)) begin
         grantCnt_q <= grantCnt_q + 16'd1;
      end
   end

   assign grant_cnt = grantCnt_q;
`endif

   assign rsp_valid = (slotState_q == SLOT_FULL);
   assign rsp_id    = rspId_q;
   assign rsp_y     = rspY_q;
   assign rsp_abcd  = rspAbcd_q;
   assign busy      = rsp_valid | (|req_valid);

endmodule
